cfg_frame_loader: RTL and testbench
===================================

Name: cfg_frame_loader

Overview:
Parametrised configuration loader for multi-cluster fabrics, successor to the single-chain programming port. It accepts a framed serial bitstream, routes the payload into one of NUM_CHAINS cluster configuration chains, and checks each frame with a CRC-8. It also supports non-destructive readback of any chain. It sits between the pad-level programming pins and the cluster array's prog_en/prog_in/prog_out chains.

Parameters:
CHAIN_LEN, 64, config bits per cluster chain (>=8)
NUM_CHAINS, 4, number of cluster chains (1..128)
SEL_W, 7, chain-select field width; a header byte carries {mode, sel[6:0]}

Ports:
clk  input  1  single clock for loader and chain shifting
rst  input  1  asynchronous, active-high reset
bit_in  input  1  serial frame bit, MSB first
bit_valid  input  1  bit_in is sampled on this cycle
chain_en  output  NUM_CHAINS  one-hot shift enable to cluster chains (prog_en)
chain_din  output  1  shared serial data into the enabled chain (prog_in)
chain_dout  input  NUM_CHAINS  serial tail of each chain (prog_out)
rb_out  output  1  readback data bit
rb_valid  output  1  rb_out is valid
busy  output  1  high in any state other than HUNT
done  output  NUM_CHAINS  per-chain "loaded with good CRC"
err_crc  output  1  sticky; the last load frame failed CRC
err_sel  output  1  sticky; the last header selected a chain >= NUM_CHAINS

Behaviour:
- Reset (async): state=HUNT; all outputs 0; sync shifter, counters and CRC cleared.
- Frame: sync byte 0xA5, header byte {mode, sel}, then a mode-dependent body. Bits are consumed only on cycles with bit_valid=1, except in READBACK.
- HUNT: an 8-bit shifter receives bit_in. When the shifter value equals 0xA5 on a valid bit, go to HDR and clear err_crc/err_sel. The shifter is cleared on exit.
- HDR: collect 8 bits. After the 8th bit:
  - sel >= NUM_CHAINS: set err_sel and return to HUNT.
  - mode=0: clear done[sel], clear CRC, counter=0, go to LOAD.
  - mode=1: counter=0, go to READBACK.
- LOAD: each valid bit, on the next cycle, drives chain_din=bit and chain_en[sel]=1 for exactly 1 cycle. This is a registered, 1-cycle latency path.
  - CRC update per bit: fb = crc[7]^bit; crc = {crc[6:0],1'b0} ^ (fb ? 8'h07 : 8'h00).
  - After CHAIN_LEN bits, go to CHECK.
- CHECK: collect 8 received CRC bits, MSB first. These bits are not forwarded to the chain (chain_en stays 0).
  - Match: done[sel]<=1.
  - Mismatch: err_crc<=1 and done[sel] stays 0.
  - Either way, return to HUNT.
- READBACK: runs for CHAIN_LEN consecutive cycles and ignores bit_valid. Each cycle:
  - chain_en[sel]=1 and chain_din=chain_dout[sel], so the chain recirculates and is unchanged afterwards.
  - rb_out=chain_dout[sel] and rb_valid=1.
  - After CHAIN_LEN cycles, return to HUNT. done is unaffected.
- chain_en is always one-hot or zero, never multi-hot. chain_din is 0 whenever chain_en is 0.
- Async reset mid-frame: aborts immediately; all done bits clear. The fabric treats partially shifted chains as invalid.
- A sync pattern inside LOAD/CHECK data is not a resync; framing is length-based.
- Counters are sized $clog2(CHAIN_LEN+1). There is no wrap; the terminal count causes the state exit.

Test Plan:
- Good load, CHAIN_LEN=16, NUM_CHAINS=4: bits A5, 02, 12 34, CRC F1 with bit_valid continuous. Required:
  - chain_en[2] pulses 16 times.
  - chain_din sequence is 0001001000110100.
  - done=4'b0100, err_crc=0.
  - busy drops after the last CRC bit.
- Bad CRC: same frame with CRC F0. Required: 16 shifts occur, done[2]=0, err_crc=1. A following A5 header clears err_crc.
- Bad select: A5 then 0x05 (sel=5 >= 4). Required: err_sel=1, no chain_en activity, return to HUNT, busy=0.
- Readback after the good load: A5 then 0x82. Required:
  - rb_valid is high for 16 cycles, bit_valid-independent.
  - rb_out=0001001000110100.
  - A second readback returns identical data (non-destructive).
- Gapped input: good frame with bit_valid toggling 1/0 and random idle bits before A5 (e.g. A4 A5 pattern overlap). Required: the loader locks on the exact A5 and the result is identical to scenario 1.
- Async reset asserted mid-LOAD (after 7 data bits) with done=4'b0100. Required: outputs 0 at once, done=0, state HUNT; a fresh good frame loads correctly.

Source files
------------

// File: rtl/cfg_frame_loader.sv
// cfg_frame_loader: framed serial configuration loader for multi-chain fabrics.
// Locks on a 0xA5 sync byte, decodes a {mode, sel} header, then either streams
// CHAIN_LEN payload bits into the selected cluster chain (checked by CRC-8,
// poly 0x07, init 0x00) or recirculates that chain for non-destructive readback.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// HUNT     | idle; sliding 8-bit window waits for the 0xA5 sync byte
// HDR      | collecting the {mode, sel} header byte
// LOAD     | forwarding CHAIN_LEN payload bits into chain sel, updating CRC
// CHECK    | collecting the 8 received CRC bits and comparing against ours
// READBACK | CHAIN_LEN free-running cycles recirculating chain sel to rb_out

module cfg_frame_loader #(
  parameter int CHAIN_LEN  = 64,
  parameter int NUM_CHAINS = 4,
  parameter int SEL_W      = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  output logic [NUM_CHAINS-1:0] chain_en,
  output logic                  chain_din,
  input  logic [NUM_CHAINS-1:0] chain_dout,
  output logic                  rb_out,
  output logic                  rb_valid,
  output logic                  busy,
  output logic [NUM_CHAINS-1:0] done,
  output logic                  err_crc,
  output logic                  err_sel
);

  localparam int              CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam logic [7:0]      SYNC_BYTE = 8'hA5;
  localparam logic [7:0]      CRC_POLY  = 8'h07;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_BYTE_BIT = CNT_W'(7);
  localparam logic [SEL_W:0]  SEL_LIMIT = (SEL_W + 1)'(NUM_CHAINS);

  typedef enum logic [2:0] {
    HUNT     = 3'd0,
    HDR      = 3'd1,
    LOAD     = 3'd2,
    CHECK    = 3'd3,
    READBACK = 3'd4
  } state_t;

  state_t                  state;
  logic [7:0]              sync_sr;
  logic [7:0]              byte_sr;
  logic [CNT_W-1:0]        bit_cnt;
  logic [7:0]              crc;
  logic [SEL_W-1:0]        sel_q;
  logic [NUM_CHAINS-1:0]   load_en;
  logic                    load_din;

  logic [7:0]              sync_shift;
  logic [7:0]              byte_shift;
  logic                    hdr_mode;
  logic [SEL_W-1:0]        hdr_sel;
  logic                    hdr_sel_bad;
  logic [NUM_CHAINS-1:0]   hdr_onehot;
  logic [NUM_CHAINS-1:0]   sel_onehot;
  logic                    dout_sel;
  logic                    in_rb;
  logic [7:0]              crc_next;

  // One serial CRC-8 step: feedback is the outgoing MSB xor the new bit.
  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  endfunction

  assign sync_shift  = {sync_sr[6:0], bit_in};
  assign byte_shift  = {byte_sr[6:0], bit_in};
  assign hdr_mode    = byte_shift[7];
  assign hdr_sel     = byte_shift[SEL_W-1:0];
  assign hdr_sel_bad = ({1'b0, hdr_sel} >= SEL_LIMIT);
  assign crc_next    = crc_step(crc, bit_in);

  // Decode the incoming header select and the latched select into one-hot masks.
  always_comb begin
    hdr_onehot = '0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_CHAINS; i++) begin
      if (SEL_W'(i) == hdr_sel) hdr_onehot[i] = 1'b1;
      if (SEL_W'(i) == sel_q)   sel_onehot[i] = 1'b1;
    end
  end

  assign dout_sel = |(chain_dout & sel_onehot);
  assign in_rb    = (state == READBACK);

  // Readback must feed the chain tail straight back in the same cycle so the
  // chain recirculates; load data comes from the registered 1-cycle path.
  always_comb begin
    chain_en  = in_rb ? sel_onehot : load_en;
    chain_din = in_rb ? dout_sel   : load_din;
    rb_out    = in_rb & dout_sel;
    rb_valid  = in_rb;
    busy      = (state != HUNT);
  end

  // Frame sequencer: sync hunt, header decode, load/check and readback timing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= HUNT;
      sync_sr  <= '0;
      byte_sr  <= '0;
      bit_cnt  <= '0;
      crc      <= '0;
      sel_q    <= '0;
      load_en  <= '0;
      load_din <= 1'b0;
      done     <= '0;
      err_crc  <= 1'b0;
      err_sel  <= 1'b0;
    end else begin
      load_en  <= '0;
      load_din <= 1'b0;
      case (state)
        HUNT: begin
          if (bit_valid) begin
            if (sync_shift == SYNC_BYTE) begin
              state   <= HDR;
              sync_sr <= '0;
              byte_sr <= '0;
              bit_cnt <= '0;
              err_crc <= 1'b0;
              err_sel <= 1'b0;
            end else begin
              sync_sr <= sync_shift;
            end
          end
        end

        HDR: begin
          if (bit_valid) begin
            if (bit_cnt == LAST_BYTE_BIT) begin
              bit_cnt <= '0;
              byte_sr <= '0;
              if (hdr_sel_bad) begin
                err_sel <= 1'b1;
                state   <= HUNT;
              end else begin
                sel_q <= hdr_sel;
                if (!hdr_mode) begin
                  done  <= done & ~hdr_onehot;
                  crc   <= '0;
                  state <= LOAD;
                end else begin
                  state <= READBACK;
                end
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              byte_sr <= byte_shift;
            end
          end
        end

        LOAD: begin
          if (bit_valid) begin
            crc      <= crc_next;
            load_en  <= sel_onehot;
            load_din <= bit_in;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              byte_sr <= '0;
              state   <= CHECK;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end

        CHECK: begin
          if (bit_valid) begin
            if (bit_cnt == LAST_BYTE_BIT) begin
              bit_cnt <= '0;
              byte_sr <= '0;
              state   <= HUNT;
              if (byte_shift == crc) done    <= done | sel_onehot;
              else                   err_crc <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              byte_sr <= byte_shift;
            end
          end
        end

        READBACK: begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            state   <= HUNT;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        default: begin
          state   <= HUNT;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Directed bench for cfg_frame_loader with a behavioural model of four
// 16-bit cluster chains attached to chain_en/chain_din/chain_dout.

module tb_cfg_frame_loader;

  localparam int CL = 16;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          bit_in;
  logic          bit_valid;
  logic [NC-1:0] chain_en;
  logic          chain_din;
  logic [NC-1:0] chain_dout;
  logic          rb_out;
  logic          rb_valid;
  logic          busy;
  logic [NC-1:0] done;
  logic          err_crc;
  logic          err_sel;

  int n_tests = 0;
  int n_fail  = 0;

  logic [CL-1:0] chain_sr [NC] = '{default: '0};

  int            en2_cnt   = 0;
  int            en_any_cnt = 0;
  int            multi_err = 0;
  int            din_err   = 0;
  int            rb_cnt    = 0;
  logic [15:0]   din_hist  = '0;
  logic [15:0]   rb_hist   = '0;

  cfg_frame_loader #(.CHAIN_LEN(CL), .NUM_CHAINS(NC), .SEL_W(7)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .chain_en(chain_en), .chain_din(chain_din), .chain_dout(chain_dout),
    .rb_out(rb_out), .rb_valid(rb_valid), .busy(busy), .done(done),
    .err_crc(err_crc), .err_sel(err_sel)
  );

  always #5 clk = ~clk;

  // Fabric model: each chain shifts chain_din in when enabled; tail is its MSB.
  always @(posedge clk) begin
    for (int i = 0; i < NC; i++)
      if (chain_en[i]) chain_sr[i] <= {chain_sr[i][CL-2:0], chain_din};
  end

  always_comb begin
    for (int i = 0; i < NC; i++) chain_dout[i] = chain_sr[i][CL-1];
  end

  // Observe shift and readback activity away from the active edge.
  always @(negedge clk) begin
    if (chain_en != '0) en_any_cnt++;
    if (chain_en[2]) begin
      en2_cnt++;
      din_hist = {din_hist[14:0], chain_din};
    end
    if ($countones(chain_en) > 1) multi_err++;
    if (chain_en == '0 && chain_din) din_err++;
    if (rb_valid) begin
      rb_cnt++;
      rb_hist = {rb_hist[14:0], rb_out};
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input bit gap);
    @(negedge clk);
    bit_in    = b;
    bit_valid = 1'b1;
    if (gap) begin
      @(negedge clk);
      bit_valid = 1'b0;
      bit_in    = ~b;
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input bit gap);
    for (int i = 7; i >= 0; i--) send_bit(v[i], gap);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bit_valid = 1'b0;
      bit_in    = 1'b0;
    end
  endtask

  // Ends one negedge after the last bit was consumed, just past that negedge.
  task automatic finish_frame();
    @(negedge clk);
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    #1;
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [15:0] data,
                            input logic [7:0] crcv, input bit gap);
    send_byte(8'hA5, gap);
    send_byte(hdr, gap);
    send_byte(data[15:8], gap);
    send_byte(data[7:0], gap);
    send_byte(crcv, gap);
  endtask

  int base;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_busy",     busy,     0);
    check_val("rst_done",     done,     0);
    check_val("rst_chain_en", chain_en, 0);
    check_val("rst_err_crc",  err_crc,  0);
    check_val("rst_err_sel",  err_sel,  0);
    check_val("rst_rb_valid", rb_valid, 0);

    // Good load into chain 2
    base = en2_cnt;
    send_frame(8'h02, 16'h1234, 8'hF1, 1'b0);
    finish_frame();
    check_val("good_busy_drop", busy, 0);
    check_val("good_en_pulses", en2_cnt - base, 16);
    check_val("good_din_seq",   din_hist, 16'h1234);
    check_val("good_done",      done, 4'b0100);
    check_val("good_err_crc",   err_crc, 0);
    check_val("good_chain2",    chain_sr[2], 16'h1234);
    idle(3);

    // Two readbacks of chain 2, bit_valid toggling throughout
    for (int r = 0; r < 2; r++) begin
      base = rb_cnt;
      send_byte(8'hA5, 1'b0);
      send_byte(8'h82, 1'b0);
      for (int i = 0; i < 24; i++) begin
        @(negedge clk);
        bit_valid = i[0];
        bit_in    = 1'b0;
      end
      finish_frame();
      check_val("rb_valid_cycles", rb_cnt - base, 16);
      check_val("rb_data",         rb_hist, 16'h1234);
      check_val("rb_chain_intact", chain_sr[2], 16'h1234);
      check_val("rb_done_kept",    done, 4'b0100);
      check_val("rb_busy_idle",    busy, 0);
    end

    // Bad CRC
    base = en2_cnt;
    send_frame(8'h02, 16'h1234, 8'hF0, 1'b0);
    finish_frame();
    check_val("bad_en_pulses", en2_cnt - base, 16);
    check_val("bad_done2",     done[2], 0);
    check_val("bad_err_crc",   err_crc, 1);

    // New sync clears err_crc, then a bad select header
    send_byte(8'hA5, 1'b0);
    finish_frame();
    check_val("sync_clears_err_crc", err_crc, 0);
    base = en_any_cnt;
    send_byte(8'h05, 1'b0);
    finish_frame();
    check_val("sel_err_sel",   err_sel, 1);
    check_val("sel_busy",      busy, 0);
    idle(4);
    check_val("sel_no_shift",  en_any_cnt - base, 0);
    check_val("sel_done",      done, 0);

    // Gapped frame with a near-miss A4 ahead of the sync byte
    base = en2_cnt;
    send_byte(8'hA4, 1'b1);
    send_frame(8'h02, 16'h1234, 8'hF1, 1'b1);
    finish_frame();
    check_val("gap_en_pulses", en2_cnt - base, 16);
    check_val("gap_din_seq",   din_hist, 16'h1234);
    check_val("gap_done",      done, 4'b0100);
    check_val("gap_err_crc",   err_crc, 0);
    check_val("gap_err_sel",   err_sel, 0);
    idle(2);

    // Async reset in the middle of a load to chain 1
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    for (int i = 0; i < 7; i++) send_bit(i[0], 1'b0);
    @(posedge clk);
    #2;
    check_val("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_val("mid_rst_chain_en", chain_en, 0);
    check_val("mid_rst_chain_din", chain_din, 0);
    check_val("mid_rst_busy",     busy, 0);
    check_val("mid_rst_done",     done, 0);
    @(negedge clk);
    rst = 1'b0;
    bit_valid = 1'b0;
    idle(2);

    base = en2_cnt;
    send_frame(8'h02, 16'h1234, 8'hF1, 1'b0);
    finish_frame();
    check_val("fresh_en_pulses", en2_cnt - base, 16);
    check_val("fresh_done",      done, 4'b0100);
    check_val("fresh_chain2",    chain_sr[2], 16'h1234);
    idle(2);

    check_val("never_multi_hot", multi_err, 0);
    check_val("din_zero_when_idle", din_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
